// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch stage.
//
// Holds the fetch PC, issues one I-cache request at a time and buffers each
// response in a small FIFO together with the branch prediction for its PC.
// A squash from the branch unit redirects the PC and flushes the FIFO.
//
// Ports:
//   clock, reset                   clock and synchronous active-high reset
//   squash, squash_pc              mispredict redirect and its target
//   fetch_pc                       current PC to the branch predictor
//   predict_direction, predict_pc  predictor answer for fetch_pc
//   icache_req/addr/gnt            request handshake (addr = current PC)
//   icache_valid, icache_inst      response from the I-cache
//   fq_pop                         dispatch consumes the head entry
//   fq_valid/pc/inst/pred_*        head entry of the fetch queue
//   fq_count                       fetch-queue occupancy
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [XLEN-1:0]             squash_pc,
    output logic [XLEN-1:0]             fetch_pc,
    input  logic                        predict_direction,
    input  logic [XLEN-1:0]             predict_pc,
    output logic                        icache_req,
    output logic [XLEN-1:0]             icache_addr,
    input  logic                        icache_gnt,
    input  logic                        icache_valid,
    input  logic [31:0]                 icache_inst,
    input  logic                        fq_pop,
    output logic                        fq_valid,
    output logic [XLEN-1:0]             fq_pc,
    output logic [31:0]                 fq_inst,
    output logic                        fq_pred_taken,
    output logic [XLEN-1:0]             fq_pred_target,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    localparam int unsigned PtrW = $clog2(FQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [PtrW-1:0]   head_q;
    logic [PtrW-1:0]   tail_q;
    logic [CntW-1:0]   count_q;

    logic [XLEN-1:0]   mem_pc     [FQ_DEPTH];
    logic [31:0]       mem_inst   [FQ_DEPTH];
    logic              mem_taken  [FQ_DEPTH];
    logic [XLEN-1:0]   mem_target [FQ_DEPTH];

    logic not_full;
    logic push;
    logic pop;

    assign not_full = count_q < CntW'(FQ_DEPTH);
    // Gated by reset so no request leaves while the FSM is being reset.
    assign icache_req = (state_q == StReq) && !squash && not_full && !reset;
    assign push       = (state_q == StWait) && icache_valid && !squash;
    assign pop        = fq_pop && (count_q != '0) && !squash;

    assign fetch_pc    = pc_q;
    assign icache_addr = pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (squash) begin
            pc_q    <= squash_pc;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // An outstanding request must have its response dropped.
            unique case (state_q)
                StReq:   state_q <= StReq;
                StWait:  state_q <= icache_valid ? StReq : StDrop;
                StDrop:  state_q <= icache_valid ? StReq : StDrop;
                default: state_q <= StReq;
            endcase
        end else begin
            if (push) tail_q <= tail_q + PtrW'(1);
            if (pop)  head_q <= head_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            unique case (state_q)
                StReq: begin
                    if (icache_req && icache_gnt) state_q <= StWait;
                end
                StWait: begin
                    if (icache_valid) begin
                        pc_q    <= predict_direction ? predict_pc : pc_q + XLEN'(4);
                        state_q <= StReq;
                    end
                end
                StDrop: begin
                    if (icache_valid) state_q <= StReq;
                end
                default: state_q <= StReq;
            endcase
        end
    end

    // Storage needs no reset: fields are only visible while fq_valid is set.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[tail_q]     <= pc_q;
            mem_inst[tail_q]   <= icache_inst;
            mem_taken[tail_q]  <= predict_direction;
            mem_target[tail_q] <= predict_direction ? predict_pc : '0;
        end
    end

    assign fq_count       = count_q;
    assign fq_valid       = count_q != '0;
    assign fq_pc          = fq_valid ? mem_pc[head_q]     : '0;
    assign fq_inst        = fq_valid ? mem_inst[head_q]   : '0;
    assign fq_pred_taken  = fq_valid ? mem_taken[head_q]  : 1'b0;
    assign fq_pred_target = fq_valid ? mem_target[head_q] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic [31:0] squash_pc;
    logic [31:0] fetch_pc;
    logic        predict_direction;
    logic [31:0] predict_pc;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_gnt;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        fq_pop;
    logic        fq_valid;
    logic [31:0] fq_pc;
    logic [31:0] fq_inst;
    logic        fq_pred_taken;
    logic [31:0] fq_pred_target;
    logic [2:0]  fq_count;

    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .squash(squash), .squash_pc(squash_pc),
        .fetch_pc(fetch_pc), .predict_direction(predict_direction), .predict_pc(predict_pc),
        .icache_req(icache_req), .icache_addr(icache_addr), .icache_gnt(icache_gnt),
        .icache_valid(icache_valid), .icache_inst(icache_inst), .fq_pop(fq_pop),
        .fq_valid(fq_valid), .fq_pc(fq_pc), .fq_inst(fq_inst),
        .fq_pred_taken(fq_pred_taken), .fq_pred_target(fq_pred_target), .fq_count(fq_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One request/response pair: gnt with the request, response one cycle later.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] inst,
                             input logic dir, input logic [31:0] ppc, input logic pop);
        icache_gnt = 1'b1;
        #1;
        vectors++;
        if (icache_req !== 1'b1) begin
            miscompares++; $display("FAIL fetch_req got %0b want 1", icache_req);
        end
        vectors++;
        if (icache_addr !== a) begin
            miscompares++; $display("FAIL fetch_addr got %h want %h", icache_addr, a);
        end
        tick();
        icache_gnt = 1'b0; icache_valid = 1'b1; icache_inst = inst;
        predict_direction = dir; predict_pc = ppc; fq_pop = pop;
        #1;
        vectors++;
        if (icache_req !== 1'b0 || fetch_pc !== a) begin
            miscompares++;
            $display("FAIL fetch_wait req=%0b pc=%h want req=0 pc=%h", icache_req, fetch_pc, a);
        end
        tick();
        icache_valid = 1'b0; predict_direction = 1'b0; predict_pc = '0; fq_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; squash = 1'b0; squash_pc = '0; predict_direction = 1'b0;
        predict_pc = '0; icache_gnt = 1'b0; icache_valid = 1'b0; icache_inst = '0;
        fq_pop = 1'b0;
        tick(); tick();
        vectors++;
        if (icache_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_req got %0b want 0", icache_req);
        end
        vectors++;
        if (fq_count !== 3'd0 || fq_valid !== 1'b0 || fq_pc !== 32'h0 ||
            fq_inst !== 32'h0 || fq_pred_target !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_queue count=%0d valid=%0b pc=%h want 0", fq_count, fq_valid, fq_pc);
        end
        vectors++;
        if (fetch_pc !== 32'h0) begin
            miscompares++; $display("FAIL reset_pc got %h want 0", fetch_pc);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) fetch_one(32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, '0, 1'b0);
        vectors++;
        if (fq_count !== 3'd4) begin
            miscompares++; $display("FAIL fill_count got %0d want 4", fq_count);
        end
        for (int i = 0; i < 3; i++) begin
            icache_gnt = 1'b1;
            #1;
            vectors++;
            if (icache_req !== 1'b0) begin
                miscompares++; $display("FAIL full_no_req got %0b want 0", icache_req);
            end
            tick();
        end
        icache_gnt = 1'b0;
        vectors++;
        if (fq_pc !== 32'h0 || fq_inst !== 32'h1000_0000 || fetch_pc !== 32'h10) begin
            miscompares++;
            $display("FAIL fill_head pc=%h inst=%h fpc=%h want 0 10000000 10", fq_pc, fq_inst, fetch_pc);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_inst [3];
        exp_pc = '{32'h8, 32'hC, 32'h10};
        exp_inst = '{32'h1000_0002, 32'h1000_0003, 32'h1000_0004};
        fq_pop = 1'b1;
        tick();
        fq_pop = 1'b0;
        #1;
        vectors++;
        if (fq_count !== 3'd3 || fq_pc !== 32'h4) begin
            miscompares++; $display("FAIL pop_one count=%0d pc=%h want 3 4", fq_count, fq_pc);
        end
        fetch_one(32'h10, 32'h1000_0004, 1'b0, '0, 1'b1);
        vectors++;
        if (fq_count !== 3'd3 || fq_pc !== 32'h8) begin
            miscompares++; $display("FAIL push_pop count=%0d pc=%h want 3 8", fq_count, fq_pc);
        end
        for (int i = 0; i < 3; i++) begin
            fq_pop = 1'b1;
            #1;
            vectors++;
            if (fq_pc !== exp_pc[i] || fq_inst !== exp_inst[i]) begin
                miscompares++;
                $display("FAIL drain_%0d pc=%h inst=%h want %h %h", i, fq_pc, fq_inst,
                         exp_pc[i], exp_inst[i]);
            end
            tick();
        end
        tick();
        fq_pop = 1'b0;
        #1;
        vectors++;
        if (fq_count !== 3'd0 || fq_valid !== 1'b0 || fq_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL empty_pop count=%0d valid=%0b pc=%h want 0", fq_count, fq_valid, fq_pc);
        end
    endtask

    task automatic test_squash_wait();
        fetch_one(32'h14, 32'h2000_0000, 1'b0, '0, 1'b0);
        icache_gnt = 1'b1;
        tick();
        icache_gnt = 1'b0; squash = 1'b1; squash_pc = 32'h200;
        #1;
        vectors++;
        if (icache_req !== 1'b0) begin
            miscompares++; $display("FAIL squash_req got %0b want 0", icache_req);
        end
        tick();
        squash = 1'b0;
        #1;
        vectors++;
        if (fq_count !== 3'd0 || fq_valid !== 1'b0 || fetch_pc !== 32'h200 || icache_req !== 1'b0) begin
            miscompares++;
            $display("FAIL squash_flush count=%0d valid=%0b pc=%h req=%0b want 0 0 200 0",
                     fq_count, fq_valid, fetch_pc, icache_req);
        end
        tick();
        icache_valid = 1'b1; icache_inst = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (icache_req !== 1'b0) begin
            miscompares++; $display("FAIL drop_req got %0b want 0", icache_req);
        end
        tick();
        icache_valid = 1'b0;
        #1;
        vectors++;
        if (fq_count !== 3'd0 || icache_req !== 1'b1 || icache_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL drop_resume count=%0d req=%0b addr=%h want 0 1 200",
                     fq_count, icache_req, icache_addr);
        end
    endtask

    task automatic test_squash_coincident();
        squash = 1'b1; squash_pc = 32'h200;
        #1;
        vectors++;
        if (icache_req !== 1'b0) begin
            miscompares++; $display("FAIL squash_in_req got %0b want 0", icache_req);
        end
        tick();
        squash = 1'b0; icache_gnt = 1'b1;
        tick();
        icache_gnt = 1'b0; icache_valid = 1'b1; squash = 1'b1; squash_pc = 32'h8;
        tick();
        icache_valid = 1'b0; squash = 1'b0;
        #1;
        vectors++;
        if (fq_count !== 3'd0 || icache_req !== 1'b1 || icache_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL squash_valid count=%0d req=%0b addr=%h want 0 1 8",
                     fq_count, icache_req, icache_addr);
        end
    endtask

    task automatic test_predict();
        fetch_one(32'h8, 32'h3000_0000, 1'b1, 32'h100, 1'b0);
        vectors++;
        if (fq_pc !== 32'h8 || fq_pred_taken !== 1'b1 || fq_pred_target !== 32'h100 ||
            fq_inst !== 32'h3000_0000) begin
            miscompares++;
            $display("FAIL pred_taken pc=%h tk=%0b tgt=%h want 8 1 100", fq_pc, fq_pred_taken,
                     fq_pred_target);
        end
        vectors++;
        if (icache_req !== 1'b1 || icache_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL pred_next req=%0b addr=%h want 1 100", icache_req, icache_addr);
        end
        fetch_one(32'h100, 32'h3000_0001, 1'b0, 32'h300, 1'b0);
        fq_pop = 1'b1;
        tick();
        fq_pop = 1'b0;
        #1;
        vectors++;
        if (fq_pc !== 32'h100 || fq_pred_taken !== 1'b0 || fq_pred_target !== 32'h0 ||
            icache_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL pred_not_taken pc=%h tk=%0b tgt=%h addr=%h want 100 0 0 104",
                     fq_pc, fq_pred_taken, fq_pred_target, icache_addr);
        end
    endtask

    task automatic test_wrap();
        squash = 1'b1; squash_pc = 32'hFFFF_FFFC;
        tick();
        squash = 1'b0;
        #1;
        vectors++;
        if (fq_count !== 3'd0 || icache_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_squash count=%0d addr=%h want 0 fffffffc", fq_count, icache_addr);
        end
        fetch_one(32'hFFFF_FFFC, 32'h4000_0000, 1'b0, '0, 1'b0);
        vectors++;
        if (icache_addr !== 32'h0 || fq_count !== 3'd1 || fq_pc !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_pc addr=%h count=%0d head=%h want 0 1 fffffffc",
                     icache_addr, fq_count, fq_pc);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_push_pop();
        test_squash_wait();
        test_squash_coincident();
        test_predict();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
